cla5_arbiter_seq: RTL and testbench

- Shares one registered 5-bit carry-lookahead adder datapath between two requesters.
- Round-robin arbitration selects a request. The block latches the granted operands into the adder's input registers and waits a programmable settle time.
- It then captures sum and carry-out and returns them, tagged with the requester ID, on a valid/ready response channel.
- Sits between the operand sources and the adder core. It is the only driver of the adder inputs.

---
 rtl/cla5_arbiter_seq_if.sv | 55 +++++
 rtl/cla5_arbiter_seq.sv | 91 +++++++++
 tb/tb_cla5_arbiter_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla5_arbiter_seq_if.sv
// Bundle of requester, adder-core and response signals for cla5_arbiter_seq.
// The slave modport is the arbiter's view; master is the surrounding system.
interface cla5_arbiter_seq_if #(
    parameter int WIDTH = 5
);
    logic             r0_valid;
    logic [WIDTH-1:0] r0_a;
    logic [WIDTH-1:0] r0_b;
    logic             r0_cin;
    logic             r0_ready;

    logic             r1_valid;
    logic [WIDTH-1:0] r1_a;
    logic [WIDTH-1:0] r1_b;
    logic             r1_cin;
    logic             r1_ready;

    logic [WIDTH-1:0] cla_a;
    logic [WIDTH-1:0] cla_b;
    logic             cla_cin;
    logic [WIDTH-1:0] cla_sum;
    logic             cla_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;

    logic             busy;

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_cin,
        output r0_ready,
        input  r1_valid, r1_a, r1_b, r1_cin,
        output r1_ready,
        output cla_a, cla_b, cla_cin,
        input  cla_sum, cla_cout,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready,
        output busy
    );

    modport master (
        output r0_valid, r0_a, r0_b, r0_cin,
        input  r0_ready,
        output r1_valid, r1_a, r1_b, r1_cin,
        input  r1_ready,
        input  cla_a, cla_b, cla_cin,
        output cla_sum, cla_cout,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/cla5_arbiter_seq.sv
// Round-robin front end for a shared registered carry-lookahead adder: grants one
// of two requesters, drives the adder inputs, waits SETTLE edges, returns the result.
module cla5_arbiter_seq #(
    parameter int WIDTH  = 5,
    parameter int SETTLE = 1     // legal range 1..15
) (
    input  logic               clk,
    input  logic               rst,
    cla5_arbiter_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic             last_grant;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        grant_id = 1'b0;
        if (bus.r0_valid && bus.r1_valid) grant_id = ~last_grant;
        else if (bus.r1_valid)            grant_id = 1'b1;

        sel_a   = grant_id ? bus.r1_a   : bus.r0_a;
        sel_b   = grant_id ? bus.r1_b   : bus.r0_b;
        sel_cin = grant_id ? bus.r1_cin : bus.r0_cin;
    end

    // A request is taken whenever we are idle and anyone asks; ready goes only to the winner.
    assign accept       = (state == IDLE) && (bus.r0_valid || bus.r1_valid);
    assign bus.r0_ready = accept && !grant_id;
    assign bus.r1_ready = accept &&  grant_id;
    assign bus.busy     = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= 1'b1;
            bus.cla_a     <= '0;
            bus.cla_b     <= '0;
            bus.cla_cin   <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.cla_a   <= sel_a;
                        bus.cla_b   <= sel_b;
                        bus.cla_cin <= sel_cin;
                        last_grant  <= grant_id;
                        bus.rsp_id  <= grant_id;
                        cnt         <= CNT_INIT;
                        state       <= EVAL;
                    end
                end
                EVAL: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.rsp_sum   <= bus.cla_sum;
                        bus.rsp_cout  <= bus.cla_cout;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla5_arbiter_seq.sv
// Self-checking bench: SETTLE=1 and SETTLE=4 instances, a vector table, corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_cla5_arbiter_seq;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla5_arbiter_seq_if #(.WIDTH(W)) bus1 ();
    cla5_arbiter_seq_if #(.WIDTH(W)) bus4 ();

    cla5_arbiter_seq #(.WIDTH(W), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    cla5_arbiter_seq #(.WIDTH(W), .SETTLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    // Adder cores: the SETTLE=1 core is ready within a cycle; the SETTLE=4 core shows
    // a corrupted result until its inputs have been stable for three falling edges.
    logic [5:0] true1, true4;
    assign true1 = 6'(bus1.cla_a) + 6'(bus1.cla_b) + 6'(bus1.cla_cin);
    assign {bus1.cla_cout, bus1.cla_sum} = true1;

    int          age4  = 0;
    logic [10:0] prev4 = '0;
    always @(negedge clk) begin
        if ({bus4.cla_a, bus4.cla_b, bus4.cla_cin} !== prev4) begin
            prev4 = {bus4.cla_a, bus4.cla_b, bus4.cla_cin};
            age4  = 0;
        end else if (age4 < 15) begin
            age4++;
        end
    end
    assign true4 = 6'(bus4.cla_a) + 6'(bus4.cla_b) + 6'(bus4.cla_cin);
    assign {bus4.cla_cout, bus4.cla_sum} = (age4 >= 3) ? true4 : ~true4;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus1.r0_valid = 1'b0; bus1.r0_a = '0; bus1.r0_b = '0; bus1.r0_cin = 1'b0;
        bus1.r1_valid = 1'b0; bus1.r1_a = '0; bus1.r1_b = '0; bus1.r1_cin = 1'b0;
        bus1.rsp_ready = 1'b1;
        bus4.r0_valid = 1'b0; bus4.r0_a = '0; bus4.r0_b = '0; bus4.r0_cin = 1'b0;
        bus4.r1_valid = 1'b0; bus4.r1_a = '0; bus4.r1_b = '0; bus4.r1_cin = 1'b0;
        bus4.rsp_ready = 1'b1;
    endtask

    typedef struct {
        logic       v0, v1;
        logic [4:0] a0, b0;
        logic       c0;
        logic [4:0] a1, b1;
        logic       c1;
        logic       id;
        logic [4:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl[8];

    // One SETTLE=1 transaction; entered and left just after a rising edge.
    task automatic run_vec(input vec_t v, input int idx);
        bus1.r0_valid = v.v0; bus1.r0_a = v.a0; bus1.r0_b = v.b0; bus1.r0_cin = v.c0;
        bus1.r1_valid = v.v1; bus1.r1_a = v.a1; bus1.r1_b = v.b1; bus1.r1_cin = v.c1;
        @(negedge clk);
        check($sformatf("v%0d_r0_ready", idx), 32'(bus1.r0_ready), 32'(v.v0 && !v.id));
        check($sformatf("v%0d_r1_ready", idx), 32'(bus1.r1_ready), 32'(v.v1 && v.id));
        @(posedge clk); #1;
        bus1.r0_valid = 1'b0; bus1.r1_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_eval_busy", idx), 32'(bus1.busy), 32'd1);
        check($sformatf("v%0d_eval_rspv", idx), 32'(bus1.rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("v%0d_rspv", idx), 32'(bus1.rsp_valid), 32'd1);
        check($sformatf("v%0d_id",   idx), 32'(bus1.rsp_id),    32'(v.id));
        check($sformatf("v%0d_sum",  idx), 32'(bus1.rsp_sum),   32'(v.sum));
        check($sformatf("v%0d_cout", idx), 32'(bus1.rsp_cout),  32'(v.cout));
        @(posedge clk); #1;
    endtask

    // One SETTLE=4 transaction with the response timing window checked edge by edge.
    task automatic txn4(input string name, input logic v0, input logic v1,
                        input logic [4:0] a0, input logic [4:0] b0, input logic c0,
                        input logic [4:0] a1, input logic [4:0] b1, input logic c1,
                        input logic eid, input logic [4:0] esum, input logic ecout);
        bus4.r0_valid = v0; bus4.r0_a = a0; bus4.r0_b = b0; bus4.r0_cin = c0;
        bus4.r1_valid = v1; bus4.r1_a = a1; bus4.r1_b = b1; bus4.r1_cin = c1;
        @(negedge clk);
        check({name, "_r0_ready"}, 32'(bus4.r0_ready), 32'(v0 && !eid));
        check({name, "_r1_ready"}, 32'(bus4.r1_ready), 32'(v1 && eid));
        @(posedge clk); #1;
        bus4.r0_valid = 1'b0; bus4.r1_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check($sformatf("%s_early_rspv%0d", name, j), 32'(bus4.rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({name, "_rspv"}, 32'(bus4.rsp_valid), 32'd1);
        check({name, "_id"},   32'(bus4.rsp_id),    32'(eid));
        check({name, "_sum"},  32'(bus4.rsp_sum),   32'(esum));
        check({name, "_cout"}, 32'(bus4.rsp_cout),  32'(ecout));
        @(posedge clk); #1;
    endtask

    initial begin
        int   m_busy, m_rspv, m_cnt, s;
        logic m_last, m_id, m_cout, g;
        logic [4:0] m_sum;

        tbl[0] = '{1'b1, 1'b0, 5'd10, 5'd7,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd17, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 5'd31, 5'd1,  1'b0, 1'b1, 5'd0,  1'b1};
        tbl[2] = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b0, 5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 5'd3,  5'd4,  1'b1, 5'd9,  5'd9,  1'b0, 1'b0, 5'd8,  1'b0};
        tbl[4] = '{1'b1, 1'b1, 5'd2,  5'd2,  1'b0, 5'd20, 5'd15, 1'b0, 1'b1, 5'd3,  1'b1};
        tbl[5] = '{1'b1, 1'b1, 5'd16, 5'd16, 1'b0, 5'd5,  5'd5,  1'b1, 1'b0, 5'd0,  1'b1};
        tbl[6] = '{1'b1, 1'b1, 5'd7,  5'd7,  1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd1,  1'b0};
        tbl[7] = '{1'b1, 1'b0, 5'd13, 5'd2,  1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd15, 1'b0};

        idle_inputs();
        rst = 1'b1;
        #12;
        check("rst_cla_a",     32'(bus1.cla_a),     32'd0);
        check("rst_cla_b",     32'(bus1.cla_b),     32'd0);
        check("rst_cla_cin",   32'(bus1.cla_cin),   32'd0);
        check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(bus1.rsp_id),    32'd0);
        check("rst_rsp_sum",   32'(bus1.rsp_sum),   32'd0);
        check("rst_rsp_cout",  32'(bus1.rsp_cout),  32'd0);
        check("rst_busy",      32'(bus1.busy),      32'd0);
        check("rst_ready",     32'({bus1.r0_ready, bus1.r1_ready}), 32'd0);
        check("rst4_busy",     32'(bus4.busy),      32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        // Operands stay on the adder after completion.
        @(negedge clk);
        check("hold_cla_a", 32'(bus1.cla_a), 32'd13);
        check("hold_cla_b", 32'(bus1.cla_b), 32'd2);
        @(posedge clk); #1;

        // Backpressure: result held for five cycles while both requesters wait.
        bus1.rsp_ready = 1'b0;
        bus1.r0_valid = 1'b1; bus1.r0_a = 5'd6; bus1.r0_b = 5'd9; bus1.r0_cin = 1'b0;
        @(negedge clk);
        check("bp_r0_ready", 32'(bus1.r0_ready), 32'd1);
        @(posedge clk); #1;
        bus1.r1_valid = 1'b1; bus1.r1_a = 5'd1; bus1.r1_b = 5'd2; bus1.r1_cin = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_rspv", k),  32'(bus1.rsp_valid), 32'd1);
            check($sformatf("bp%0d_sum", k),   32'(bus1.rsp_sum),   32'd15);
            check($sformatf("bp%0d_cout", k),  32'(bus1.rsp_cout),  32'd0);
            check($sformatf("bp%0d_id", k),    32'(bus1.rsp_id),    32'd0);
            check($sformatf("bp%0d_ready", k), 32'({bus1.r0_ready, bus1.r1_ready}), 32'd0);
            check($sformatf("bp%0d_busy", k),  32'(bus1.busy),      32'd1);
            @(posedge clk); #1;
        end
        bus1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_busy",     32'(bus1.busy),      32'd0);
        check("bp_idle_rspv",     32'(bus1.rsp_valid), 32'd0);
        check("bp_next_r1_ready", 32'(bus1.r1_ready),  32'd1);
        check("bp_next_r0_ready", 32'(bus1.r0_ready),  32'd0);
        @(posedge clk); #1;
        bus1.r0_valid = 1'b0; bus1.r1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_next_rspv", 32'(bus1.rsp_valid), 32'd1);
        check("bp_next_sum",  32'(bus1.rsp_sum),   32'd3);
        check("bp_next_id",   32'(bus1.rsp_id),    32'd1);
        @(posedge clk); #1;

        // SETTLE=4 timing and capture.
        txn4("s4a", 1'b1, 1'b0, 5'd9, 5'd12, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd22, 1'b0);
        txn4("s4b", 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd20, 5'd13, 1'b0, 1'b1, 5'd1, 1'b1);

        // Reset asserted while both instances are evaluating.
        bus4.r0_valid = 1'b1; bus4.r0_a = 5'd7; bus4.r0_b = 5'd5; bus4.r0_cin = 1'b1;
        bus1.r1_valid = 1'b1; bus1.r1_a = 5'd3; bus1.r1_b = 5'd3; bus1.r1_cin = 1'b0;
        @(posedge clk); #1;
        bus4.r0_valid = 1'b0; bus1.r1_valid = 1'b0;
        @(negedge clk);
        check("mid_busy_before", 32'(bus4.busy),  32'd1);
        check("mid_cla_before",  32'(bus4.cla_a), 32'd7);
        #2 rst = 1'b1;
        #1;
        check("mid_busy",    32'(bus4.busy),      32'd0);
        check("mid_rspv",    32'(bus4.rsp_valid), 32'd0);
        check("mid_cla",     32'({bus4.cla_a, bus4.cla_b, bus4.cla_cin}), 32'd0);
        check("mid_rsp",     32'({bus4.rsp_id, bus4.rsp_sum, bus4.rsp_cout}), 32'd0);
        check("mid_ready",   32'({bus4.r0_ready, bus4.r1_ready}), 32'd0);
        check("mid1_busy",   32'(bus1.busy),      32'd0);
        check("mid1_cla",    32'({bus1.cla_a, bus1.cla_b, bus1.cla_cin}), 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_rspv%0d", k), 32'({bus4.rsp_valid, bus1.rsp_valid}), 32'd0);
            check($sformatf("post_rst_busy%0d", k), 32'({bus4.busy, bus1.busy}), 32'd0);
        end
        @(posedge clk); #1;
        txn4("tie", 1'b1, 1'b1, 5'd1, 5'd1, 1'b0, 5'd4, 5'd4, 1'b0, 1'b0, 5'd2, 1'b0);

        // Randomized traffic on the SETTLE=1 instance against a transaction-level model.
        m_busy = 0; m_rspv = 0; m_cnt = 0; m_last = 1'b1;
        m_id = 1'b0; m_sum = '0; m_cout = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus1.r0_valid  = 1'($urandom_range(0, 1));
            bus1.r1_valid  = 1'($urandom_range(0, 1));
            bus1.r0_a      = 5'($urandom_range(0, 31));
            bus1.r0_b      = 5'($urandom_range(0, 31));
            bus1.r0_cin    = 1'($urandom_range(0, 1));
            bus1.r1_a      = 5'($urandom_range(0, 31));
            bus1.r1_b      = 5'($urandom_range(0, 31));
            bus1.r1_cin    = 1'($urandom_range(0, 1));
            bus1.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus1.r0_valid && bus1.r1_valid) g = (m_last == 1'b0);
            else                                g = bus1.r1_valid;
            check($sformatf("rnd%0d_r0_ready", c), 32'(bus1.r0_ready),
                  32'(m_busy == 0 && bus1.r0_valid && g == 1'b0));
            check($sformatf("rnd%0d_r1_ready", c), 32'(bus1.r1_ready),
                  32'(m_busy == 0 && bus1.r1_valid && g == 1'b1));
            check($sformatf("rnd%0d_busy", c), 32'(bus1.busy), 32'(m_busy));
            check($sformatf("rnd%0d_rspv", c), 32'(bus1.rsp_valid), 32'(m_rspv));
            if (m_rspv != 0) begin
                check($sformatf("rnd%0d_rsp", c),
                      32'({bus1.rsp_id, bus1.rsp_cout, bus1.rsp_sum}),
                      32'({m_id, m_cout, m_sum}));
            end
            if (m_busy == 0) begin
                if (bus1.r0_valid || bus1.r1_valid) begin
                    s = g ? int'(bus1.r1_a) + int'(bus1.r1_b) + int'(bus1.r1_cin)
                          : int'(bus1.r0_a) + int'(bus1.r0_b) + int'(bus1.r0_cin);
                    m_busy = 1; m_cnt = 1; m_last = g; m_id = g;
                    m_sum  = 5'(s % 32);
                    m_cout = (s >= 32);
                end
            end else if (m_rspv == 0) begin
                m_cnt--;
                if (m_cnt == 0) m_rspv = 1;
            end else if (bus1.rsp_ready) begin
                m_rspv = 0; m_busy = 0;
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
